uart_lcd_sequencer: RTL and testbench

//  Consumes bytes from the UART receiver (rx_data/rx_ready strobe), buffers them in a FIFO and

---
 rtl/uart_lcd_pkg.sv | 49 ++++
 rtl/lcd_byte_fifo.sv | 58 +++++
 rtl/uart_lcd_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_uart_lcd_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_lcd_pkg.sv
// Shared types and constants for the UART-to-HD44780 LCD sequencer.
//  state_e      : sequencer FSM states
//  LCD_*        : HD44780 command bytes used by init, newline, return and wrap
//  init_cmd()   : init command for a given step of the power-up sequence
//  is_printable : bytes that are written to the display as characters
package uart_lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_INIT     = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_PULSE    = 3'd4,
        ST_HOLD     = 3'd5,
        ST_WAIT     = 3'd6,
        ST_WRAP     = 3'd7
    } state_e;

    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_LINE0     = 8'h80;
    localparam logic [7:0] LCD_LINE1     = 8'hC0;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned COL_W    = 4;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(15);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_8B2L;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY_INC;
            default: return LCD_CLEAR;
        endcase
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read.
//  clk, rst       : clock, asynchronous active-high reset (pointers only)
//  push, din      : write din when push and not full (or full with a pop this cycle)
//  pop            : consume dout when not empty
//  dout           : head entry, valid when empty=0
//  full, empty    : occupancy flags
module lcd_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_lcd_sequencer.sv
// Buffers UART RX bytes and replays them as HD44780 8-bit write cycles to a
// 16x2 LCD: power-up init, characters, CR (clear/home), LF (line toggle) and
// automatic wrap after column 15.
//  clk, rst           : clock, asynchronous active-high reset
//  rx_data, rx_ready  : received byte and its 1-cycle valid strobe
//  lcd_rs/rw/e/d      : LCD pins (rw tied low, write only)
//  busy               : init running, bytes pending or write cycle in flight
//  overflow           : sticky, a byte was dropped on a full FIFO
module uart_lcd_sequencer
    import uart_lcd_pkg::*;
#(
    parameter int unsigned E_PULSE_CYC    = 25,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLR_WAIT_CYC   = 100000,
    parameter int unsigned PWRUP_WAIT_CYC = 1000000,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_d,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned MAX_WAIT = max2(max2(E_PULSE_CYC, CMD_WAIT_CYC),
                                            max2(CLR_WAIT_CYC, PWRUP_WAIT_CYC));
    localparam int unsigned CNT_W = $clog2(MAX_WAIT) + 1;

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWRUP_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic             init_active_q, init_active_d;
    logic             wrap_pend_q, wrap_pend_d;
    logic             line_q, line_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_e_q, lcd_e_d;
    logic [7:0]       lcd_d_q, lcd_d_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty;
    logic             pop_c, push_c, byte_valid_c;
    logic [CNT_W-1:0] wait_last_c;

    // FIFO handshake: pop happens in IDLE whenever a byte is waiting.
    assign pop_c        = (state_q == ST_IDLE) & ~fifo_empty;
    assign push_c       = rx_ready & (~fifo_full | pop_c);
    assign byte_valid_c = is_printable(fifo_dout) ||
                          (fifo_dout == ASCII_CR) || (fifo_dout == ASCII_LF);
    // The clear command needs the long settle; the latched bus tells us what was sent.
    assign wait_last_c  = (~lcd_rs_q && (lcd_d_q == LCD_CLEAR)) ? CLR_LAST : CMD_LAST;

    lcd_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_PWR_WAIT;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PWR_WAIT: if (cnt_q == PWR_LAST) state_d = ST_INIT;
            ST_INIT:     state_d = ST_SETUP;
            ST_IDLE:     if (pop_c && byte_valid_c) state_d = ST_SETUP;
            ST_SETUP:    state_d = ST_PULSE;
            ST_PULSE:    if (cnt_q == PULSE_LAST) state_d = ST_HOLD;
            ST_HOLD:     state_d = ST_WAIT;
            ST_WAIT: begin
                if (cnt_q == wait_last_c) begin
                    if (init_active_q)    state_d = (init_idx_q == 2'd3) ? ST_IDLE : ST_INIT;
                    else if (wrap_pend_q) state_d = ST_WRAP;
                    else                  state_d = ST_IDLE;
                end
            end
            ST_WRAP:     state_d = ST_SETUP;
            default:     state_d = ST_PWR_WAIT;
        endcase
    end

    // Output, counter and cursor logic.
    always_comb begin
        cnt_d         = cnt_q;
        init_idx_d    = init_idx_q;
        init_active_d = init_active_q;
        wrap_pend_d   = wrap_pend_q;
        line_d        = line_q;
        col_d         = col_q;
        lcd_rs_d      = lcd_rs_q;
        lcd_d_d       = lcd_d_q;
        lcd_e_d       = (state_d == ST_PULSE);
        overflow_d    = overflow_q | (rx_ready & fifo_full & ~pop_c);
        // Conservative by one cycle when the last byte popped is discarded.
        busy_d        = (state_d != ST_IDLE) | ~fifo_empty | push_c;

        // Counter runs only in timed states and restarts on every state change.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_PWR_WAIT) || (state_q == ST_PULSE) ||
                     (state_q == ST_WAIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_INIT: begin
                lcd_rs_d = 1'b0;
                lcd_d_d  = init_cmd(init_idx_q);
            end
            ST_IDLE: begin
                if (pop_c) begin
                    if (is_printable(fifo_dout)) begin
                        lcd_rs_d = 1'b1;
                        lcd_d_d  = fifo_dout;
                        // Column 15 stays put until WRAP moves the cursor.
                        if (col_q == COL_LAST) wrap_pend_d = 1'b1;
                        else                   col_d = col_q + COL_W'(1);
                    end else if (fifo_dout == ASCII_CR) begin
                        lcd_rs_d = 1'b0;
                        lcd_d_d  = LCD_CLEAR;
                        line_d   = 1'b0;
                        col_d    = '0;
                    end else if (fifo_dout == ASCII_LF) begin
                        lcd_rs_d = 1'b0;
                        lcd_d_d  = line_q ? LCD_LINE0 : LCD_LINE1;
                        line_d   = ~line_q;
                        col_d    = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (state_d == ST_INIT) init_idx_d = init_idx_q + 2'(1);
                if (init_active_q && (state_d == ST_IDLE)) init_active_d = 1'b0;
            end
            ST_WRAP: begin
                lcd_rs_d    = 1'b0;
                lcd_d_d     = line_q ? LCD_LINE0 : LCD_LINE1;
                line_d      = ~line_q;
                col_d       = '0;
                wrap_pend_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            init_idx_q    <= '0;
            init_active_q <= 1'b1;
            wrap_pend_q   <= 1'b0;
            line_q        <= 1'b0;
            col_q         <= '0;
            lcd_rs_q      <= 1'b0;
            lcd_e_q       <= 1'b0;
            lcd_d_q       <= '0;
            busy_q        <= 1'b1;
            overflow_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            init_idx_q    <= init_idx_d;
            init_active_q <= init_active_d;
            wrap_pend_q   <= wrap_pend_d;
            line_q        <= line_d;
            col_q         <= col_d;
            lcd_rs_q      <= lcd_rs_d;
            lcd_e_q       <= lcd_e_d;
            lcd_d_q       <= lcd_d_d;
            busy_q        <= busy_d;
            overflow_q    <= overflow_d;
        end
    end

    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = lcd_e_q;
    assign lcd_d    = lcd_d_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_lcd_sequencer.sv
// Self-checking bench for uart_lcd_sequencer: randomized and directed byte
// streams checked against a cursor-level model of the expected LCD writes.
module tb_uart_lcd_sequencer;

    localparam int E_CYC   = 2;
    localparam int CMD_CYC = 4;
    localparam int CLR_CYC = 8;
    localparam int PWR_CYC = 10;
    localparam int DEPTH   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e, busy, overflow;
    logic [7:0] lcd_d;

    uart_lcd_sequencer #(
        .E_PULSE_CYC    (E_CYC),
        .CMD_WAIT_CYC   (CMD_CYC),
        .CLR_WAIT_CYC   (CLR_CYC),
        .PWRUP_WAIT_CYC (PWR_CYC),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_d    (lcd_d),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int last_rise_cyc = 0;

    // Expected LCD writes as {rs, d}, in order.
    logic [8:0] exp_q [$];
    int m_line = 0;
    int m_col  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        m_line = 0;
        m_col  = 0;
    endfunction

    // Cursor model: 16 columns, 2 lines, text wraps to the other line.
    function automatic void model_feed(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({1'b1, b});
            if (m_col == 15) begin
                exp_q.push_back((m_line == 0) ? 9'h0C0 : 9'h080);
                m_line = 1 - m_line;
                m_col  = 0;
            end else begin
                m_col++;
            end
        end else if (b == 8'h0D) begin
            exp_q.push_back(9'h001);
            m_line = 0;
            m_col  = 0;
        end else if (b == 8'h0A) begin
            m_line = 1 - m_line;
            exp_q.push_back((m_line == 0) ? 9'h080 : 9'h0C0);
            m_col = 0;
        end
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] ctl [7];
        ctl = '{8'h0D, 8'h0A, 8'h07, 8'h00, 8'h7F, 8'h1B, 8'hFF};
        if ($urandom_range(0, 9) < 7) return 8'($urandom_range(32, 126));
        return ctl[$urandom_range(0, 6)];
    endfunction

    // Watches every enable pulse: payload, pulse width, bus hold and settle gap.
    task automatic monitor();
        bit         prev_e    = 1'b0;
        int         hi        = 0;
        int         fall_c    = 0;
        bit         have_fall = 1'b0;
        logic [8:0] last_ev   = '0;
        logic [8:0] ev;
        int         need;
        int         gap;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_e    = 1'b0;
                hi        = 0;
                have_fall = 1'b0;
            end else begin
                if (lcd_e && !prev_e) begin
                    ev            = {lcd_rs, lcd_d};
                    last_rise_cyc = cyc;
                    check("rw_low", 32'(lcd_rw), 32'(0));
                    if (have_fall) begin
                        need = (last_ev == 9'h001) ? CLR_CYC : CMD_CYC;
                        gap  = cyc - fall_c;
                        check("settle_gap", (gap >= need) ? need : gap, need);
                    end
                    check("pulse_expected", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) check("pulse_word", 32'(ev), 32'(exp_q.pop_front()));
                    last_ev = ev;
                    hi      = 1;
                end else if (lcd_e) begin
                    hi++;
                end else if (prev_e) begin
                    check("e_width", hi, E_CYC);
                    check("d_hold", 32'({lcd_rs, lcd_d}), 32'(last_ev));
                    fall_c    = cyc;
                    have_fall = 1'b1;
                end
                prev_e = lcd_e;
            end
        end
    endtask

    task automatic put(input logic [7:0] b, input bit modeled);
        rx_data  = b;
        rx_ready = 1'b1;
        if (modeled) model_feed(b);
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
        check({tag, "_all_writes"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset immediately (mid-cycle), checks reset values, releases after a posedge.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst_e"}, 32'(lcd_e), 32'(0));
        check({tag, "_rst_rs"}, 32'(lcd_rs), 32'(0));
        check({tag, "_rst_d"}, 32'(lcd_d), 32'(0));
        check({tag, "_rst_busy"}, 32'(busy), 32'(1));
        check({tag, "_rst_ovf"}, 32'(overflow), 32'(0));
        repeat (2) @(posedge clk);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int s;
        int n;
        int len;
        logic [7:0] b;

        fork
            monitor();
        join_none

        // Reset state and power-up init sequence.
        #2;
        apply_reset("por");
        drain("init");

        // Single character: payload, pulse width and latency from strobe.
        put(8'h41, 1'b1);
        s = cyc;
        drain("char");
        check("latency", last_rise_cyc - s, 2);

        // Line wrap both ways.
        put(8'h0D, 1'b1);
        drain("home");
        for (int i = 0; i < 16; i++) put(8'h30, 1'b1);
        put(8'h31, 1'b1);
        drain("wrap_l1");
        for (int i = 0; i < 16; i++) put(8'h32, 1'b1);
        drain("wrap_l0");

        // Control characters.
        put(8'h0D, 1'b1);
        put(8'h0A, 1'b1);
        put(8'h07, 1'b1);
        drain("ctrl");
        check("no_ovf_directed", 32'(overflow), 32'(0));

        // Random bursts that never exceed the FIFO depth.
        for (int k = 0; k < 25; k++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                b = rand_byte();
                put(b, 1'b1);
            end
            drain("rand");
        end
        check("no_ovf_random", 32'(overflow), 32'(0));

        // Overflow while init holds the FIFO: 16 kept in order, 17th dropped.
        @(negedge clk);
        apply_reset("ovf");
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(32, 126));
            put(b, 1'b1);
        end
        check("ovf_before", 32'(overflow), 32'(0));
        put(8'h5A, 1'b0);
        check("ovf_set", 32'(overflow), 32'(1));
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 32'(1));

        // Reset while enable is high: pending bytes discarded, init restarts.
        @(negedge clk);
        apply_reset("mid");
        for (int i = 0; i < 3; i++) put(8'h45, 1'b0);
        n = 0;
        @(negedge clk);
        while (!lcd_e && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_saw_pulse", 32'(lcd_e), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_abort_e", 32'(lcd_e), 32'(0));
        check("mid_abort_busy", 32'(busy), 32'(1));
        check("mid_abort_d", 32'(lcd_d), 32'(0));
        repeat (2) @(posedge clk);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain("mid_reinit");
        check("mid_ovf_clear", 32'(overflow), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
